// File: rtl/mux2bit_capture_fifo_if.sv
// Handshake/data bundle between the 2-bit mux producer and the capture FIFO.
// With FIFO_ERR_FLAGS_EN defined, sticky overflow/underflow flags are added.
interface mux2bit_capture_fifo_if #(
   parameter int DATA_WIDTH = 2,
   parameter int ADDR_WIDTH = 2
);
   logic [DATA_WIDTH-1:0] in_data;
   logic                  push;
   logic                  pop;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  full;
   logic                  empty;
   logic [ADDR_WIDTH:0]   count;
`ifdef FIFO_ERR_FLAGS_EN
   logic                  overflow;
   logic                  underflow;
`endif

   modport master (
      output in_data, push, pop,
      input  out_data, full, empty, count
`ifdef FIFO_ERR_FLAGS_EN
      , input overflow, underflow
`endif
   );

   modport slave (
      input  in_data, push, pop,
      output out_data, full, empty, count
`ifdef FIFO_ERR_FLAGS_EN
      , output overflow, underflow
`endif
   );
endinterface

// File: rtl/mux2bit_capture_fifo.sv
// Show-ahead synchronous FIFO buffering the 2-bit mux output for downstream logic.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module mux2bit_capture_fifo #(
   parameter int DATA_WIDTH = 2,
   parameter int DEPTH      = 4,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   mux2bit_capture_fifo_if.slave       bus
);
   localparam logic [ADDR_WIDTH:0]   FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_q;
   logic                  full;
   logic                  empty;
   logic                  wr_en;
   logic                  rd_en;

   // Flags come only from registered count, so push/pop never reach them combinationally.
   assign full  = (count_q == FULL_COUNT);
   assign empty = (count_q == '0);

   // A pop on a full FIFO frees the slot the simultaneous push lands in.
   assign wr_en = bus.push & (~full | bus.pop);
   assign rd_en = bus.pop & ~empty;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
         if (wr_en && !rd_en)      count_q <= count_q + COUNT_ONE;
         else if (rd_en && !wr_en) count_q <= count_q - COUNT_ONE;
      end
   end

   // NOTE: storage has no reset; stale words are unreachable because empty masks the read port.
   always_ff @(posedge clk) begin
      if (!reset && wr_en) mem[wr_ptr] <= bus.in_data;
   end

   assign bus.out_data = empty ? '0 : mem[rd_ptr];
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.count    = count_q;

`ifdef FIFO_ERR_FLAGS_EN
   logic overflow_q;
   logic underflow_q;

   // Sticky until reset; a push on full is legal when paired with a pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.push && full && !bus.pop) overflow_q  <= 1'b1;
         if (bus.pop && empty)             underflow_q <= 1'b1;
      end
   end

   assign bus.overflow  = overflow_q;
   assign bus.underflow = underflow_q;
`endif
endmodule
